// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment display scheduler.
package seg7_pkg;

    // Common glyphs in abcdefgh bit order (a = bit 7, h/dp = bit 0).
    typedef enum logic [7:0] {
        ZERO  = 8'b1111_1100,
        ONE   = 8'b0110_0000,
        TWO   = 8'b1101_1010,
        THREE = 8'b1111_0010,
        FOUR  = 8'b0110_0110,
        SPACE = 8'b0000_0000,
        S     = 8'b1011_0110,
        L     = 8'b0001_1100
    } seven_seg_encoding_e;

    typedef enum logic {
        OWNER_GAME  = 1'b0,
        OWNER_DEBUG = 1'b1
    } owner_e;

    typedef enum logic {
        BLANK  = 1'b0,
        ACTIVE = 1'b1
    } scan_state_e;

    // Bits needed for a counter that must hold max_value; never less than 1.
    function automatic int cnt_width(input int max_value);
        return (max_value > 0) ? $clog2(max_value + 1) : 1;
    endfunction

endpackage

// File: rtl/seg7_strobe_gen.sv
// Free-running modulo-period counter emitting a one-cycle strobe on its last count.
module seg7_strobe_gen
    import seg7_pkg::*;
#(
    parameter int period_cycles = 12500
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic strobe
);

    localparam int            CW   = cnt_width(period_cycles - 1);
    localparam logic [CW-1:0] LAST = CW'(period_cycles - 1);

    logic [CW-1:0] cnt_reg;

    // Strobe marks the final cycle of each period; a held clear suppresses it.
    assign strobe = (cnt_reg == LAST) && !clr;

    // Count 0..period-1 and wrap; clear holds the count at zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/seg7_display_scheduler.sv
// Multiplexed seven-segment scanner with per-slot blanking, per-frame snapshot
// and game/debug display ownership arbitration.
module seg7_display_scheduler
    import seg7_pkg::*;
#(
    parameter int w_digit      = 4,
    parameter int slot_cycles  = 12500,
    parameter int blank_cycles = 16,
    parameter int ms_cycles    = 50000,
    parameter int hold_ms      = 2000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [w_digit*8-1:0] game_digits,
    input  logic                 debug_valid,
    input  logic [w_digit*8-1:0] debug_digits,
    output logic                 debug_ready,
    input  logic                 force_game,
    output logic [7:0]           abcdefgh,
    output logic [w_digit-1:0]   digit,
    output logic                 owner
);

    localparam int            IW        = cnt_width(w_digit - 1);
    localparam int            BW        = cnt_width(blank_cycles);
    localparam int            HW        = cnt_width(hold_ms);
    localparam logic [IW-1:0] IDX_LAST  = IW'(w_digit - 1);
    localparam logic [BW-1:0] BLANK_LEN = BW'(blank_cycles);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(hold_ms);

    logic                 slot_wrap;
    logic                 ms_tick;
    logic                 ms_clr;
    logic [IW-1:0]        idx_reg;
    logic [BW-1:0]        blank_cnt_reg;
    logic                 slot_first_reg;
    logic                 rst_q_reg;
    logic                 frame_start;
    logic                 accept;
    scan_state_e          scan_state;
    owner_e               own_state_reg;
    owner_e               own_state_next;
    owner_e               owner_reg;
    logic [HW-1:0]        hold_reg;
    logic [HW-1:0]        hold_next;
    logic [w_digit*8-1:0] debug_buf_reg;
    logic [w_digit*8-1:0] snapshot_reg;
    logic [w_digit*8-1:0] snapshot_view;
    logic [7:0]           field [w_digit];
    logic [w_digit-1:0]   digit_next;
    logic [7:0]           abcdefgh_next;

    // Slot timebase: one strobe on the last cycle of every digit slot.
    seg7_strobe_gen #(
        .period_cycles(slot_cycles)
    ) u_slot_strobe (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .strobe(slot_wrap)
    );

    // Millisecond prescaler only runs while a debug message holds ownership,
    // so it always starts from zero at acceptance.
    assign ms_clr = (own_state_reg != OWNER_DEBUG);

    seg7_strobe_gen #(
        .period_cycles(ms_cycles)
    ) u_ms_strobe (
        .clk   (clk),
        .rst   (rst),
        .clr   (ms_clr),
        .strobe(ms_tick)
    );

    // Digit index advances per slot; a saturating counter tracks the blank
    // window at the start of each slot, and a flag marks slot counter == 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg        <= '0;
            blank_cnt_reg  <= '0;
            slot_first_reg <= 1'b1;
        end else begin
            slot_first_reg <= slot_wrap;
            if (slot_wrap) begin
                blank_cnt_reg <= '0;
                idx_reg       <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
            end else if (blank_cnt_reg < BLANK_LEN) begin
                blank_cnt_reg <= blank_cnt_reg + BW'(1);
            end
        end
    end

    assign frame_start = slot_first_reg && (idx_reg == '0);
    assign scan_state  = (blank_cnt_reg < BLANK_LEN) ? BLANK : ACTIVE;

    // On the boundary cycle the freshly selected source is shown directly so
    // a zero-length blank window still displays the new frame.
    always_comb begin
        snapshot_view = snapshot_reg;
        if (frame_start) begin
            snapshot_view = (own_state_reg == OWNER_GAME) ? game_digits : debug_buf_reg;
        end
    end

    // Split the snapshot into per-digit fields and build the one-hot enable.
    for (genvar gi = 0; gi < w_digit; gi++) begin : g_digit
        assign field[gi]      = snapshot_view[gi*8 +: 8];
        assign digit_next[gi] = (scan_state == ACTIVE) && (idx_reg == IW'(gi));
    end

    assign abcdefgh_next = (scan_state == ACTIVE) ? field[idx_reg] : 8'h00;

    // Registered pin drivers, frame snapshot and visible owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            abcdefgh     <= 8'h00;
            digit        <= '0;
            owner_reg    <= OWNER_GAME;
            snapshot_reg <= '0;
        end else begin
            abcdefgh <= abcdefgh_next;
            digit    <= digit_next;
            if (frame_start) begin
                snapshot_reg <= snapshot_view;
                owner_reg    <= own_state_reg;
            end
        end
    end

    assign owner = owner_reg;

    // The requester is also held off for the first cycle after reset.
    assign debug_ready = (own_state_reg == OWNER_GAME) && !force_game && !rst && !rst_q_reg;
    assign accept      = debug_valid && debug_ready;

    // Ownership next-state: force wins, then acceptance, then hold expiry.
    always_comb begin
        own_state_next = own_state_reg;
        hold_next      = hold_reg;
        if (force_game) begin
            own_state_next = OWNER_GAME;
            hold_next      = '0;
        end else begin
            case (own_state_reg)
                OWNER_GAME: begin
                    if (accept) begin
                        own_state_next = OWNER_DEBUG;
                        hold_next      = HOLD_LOAD;
                    end
                end
                OWNER_DEBUG: begin
                    if (hold_reg == '0) begin
                        own_state_next = OWNER_GAME;
                    end else if (ms_tick) begin
                        hold_next = hold_reg - HW'(1);
                        if (hold_reg == HW'(1)) begin
                            own_state_next = OWNER_GAME;
                        end
                    end
                end
                default: begin
                    own_state_next = OWNER_GAME;
                    hold_next      = '0;
                end
            endcase
        end
    end

    // Ownership state, hold counter and the latched debug message.
    always_ff @(posedge clk) begin
        if (rst) begin
            own_state_reg <= OWNER_GAME;
            hold_reg      <= '0;
            debug_buf_reg <= '0;
            rst_q_reg     <= 1'b1;
        end else begin
            own_state_reg <= own_state_next;
            hold_reg      <= hold_next;
            rst_q_reg     <= 1'b0;
            if (accept) begin
                debug_buf_reg <= debug_digits;
            end
        end
    end

endmodule

// File: tb/tb_seg7_display_scheduler.sv
// Directed testbench for seg7_display_scheduler with small timing parameters.
module tb_seg7_display_scheduler;

    localparam logic [31:0] GAME_A = 32'h44_33_22_11;
    localparam logic [31:0] DBG_A  = 32'hDD_CC_BB_AA;
    localparam logic [31:0] GAME_B = 32'h08_04_02_01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] game_digits = '0;
    logic        debug_valid = 1'b0;
    logic [31:0] debug_digits = '0;
    logic        debug_ready;
    logic        force_game = 1'b0;
    logic [7:0]  abcdefgh;
    logic [3:0]  digit;
    logic        owner;

    int tests_run    = 0;
    int tests_failed = 0;
    int t            = 0;

    seg7_display_scheduler #(
        .w_digit     (4),
        .slot_cycles (8),
        .blank_cycles(2),
        .ms_cycles   (10),
        .hold_ms     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .game_digits (game_digits),
        .debug_valid (debug_valid),
        .debug_digits(debug_digits),
        .debug_ready (debug_ready),
        .force_game  (force_game),
        .abcdefgh    (abcdefgh),
        .digit       (digit),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    // Expected {digit, abcdefgh} for outputs produced from frame phase q.
    function automatic logic [11:0] exp_scan(input int q, input logic [31:0] data);
        int         c;
        int         k;
        logic [3:0] d;
        c = q % 8;
        k = (q / 8) % 4;
        if (c < 2) return 12'h000;
        d = 4'b0001 << k;
        return {d, data[k*8 +: 8]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Reset for two edges; t = 0 is the first cycle after release.
    task automatic do_reset(input logic [31:0] g);
        game_digits = g;
        debug_valid = 1'b0;
        force_game  = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        t   = 0;
    endtask

    task automatic test_reset();
        game_digits  = GAME_A;
        debug_digits = DBG_A;
        debug_valid  = 1'b1;
        force_game   = 1'b0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({digit, abcdefgh} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_pins got digit=%b seg=%h want 0/00", digit, abcdefgh);
        end
        tests_run++;
        if (owner !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_owner got %b want 0", owner);
        end
        tests_run++;
        if (debug_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready_in_rst got %b want 0", debug_ready);
        end
        rst = 1'b0;
        t   = 0;
        #1;
        tests_run++;
        if (debug_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready_first got %b want 0", debug_ready);
        end
        tests_run++;
        if ({owner, digit, abcdefgh} !== 13'h0) begin
            tests_failed++;
            $display("FAIL reset_first_out got owner=%b digit=%b seg=%h want 0", owner, digit, abcdefgh);
        end
        debug_valid = 1'b0;
        tick();
        tests_run++;
        if (debug_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready_after got %b want 1", debug_ready);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_scan();
        do_reset(GAME_A);
        while (t < 64) begin
            tick();
            tests_run++;
            if ({digit, abcdefgh} !== exp_scan(t - 1, GAME_A)) begin
                tests_failed++;
                $display("FAIL scan t=%0d got digit=%b seg=%h want %h", t, digit, abcdefgh, exp_scan(t - 1, GAME_A));
            end
            tests_run++;
            if (owner !== 1'b0) begin
                tests_failed++;
                $display("FAIL scan_owner t=%0d got %b want 0", t, owner);
            end
        end
        $display("[TB] test_scan done");
    endtask

    task automatic test_debug_handshake();
        logic [31:0] d;
        do_reset(GAME_A);
        while (t < 20) tick();
        debug_valid  = 1'b1;
        debug_digits = DBG_A;
        tests_run++;
        if (debug_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL hs_ready_before got %b want 1", debug_ready);
        end
        tick();
        debug_valid = 1'b0;
        while (t <= 96) begin
            d = (((t - 1) / 32) == 1) ? DBG_A : GAME_A;
            tests_run++;
            if (debug_ready !== (t > 50)) begin
                tests_failed++;
                $display("FAIL hs_ready t=%0d got %b want %b", t, debug_ready, (t > 50));
            end
            tests_run++;
            if (owner !== (t >= 33 && t <= 64)) begin
                tests_failed++;
                $display("FAIL hs_owner t=%0d got %b want %b", t, owner, (t >= 33 && t <= 64));
            end
            tests_run++;
            if ({digit, abcdefgh} !== exp_scan(t - 1, d)) begin
                tests_failed++;
                $display("FAIL hs_scan t=%0d got digit=%b seg=%h want %h", t, digit, abcdefgh, exp_scan(t - 1, d));
            end
            tick();
        end
        $display("[TB] test_debug_handshake done");
    endtask

    task automatic test_mid_frame();
        logic [31:0] d;
        do_reset(GAME_A);
        while (t < 10) tick();
        game_digits = 32'h0;
        while (t <= 64) begin
            d = ((t - 1) < 32) ? GAME_A : 32'h0;
            tests_run++;
            if ({digit, abcdefgh} !== exp_scan(t - 1, d)) begin
                tests_failed++;
                $display("FAIL midframe t=%0d got digit=%b seg=%h want %h", t, digit, abcdefgh, exp_scan(t - 1, d));
            end
            tick();
        end
        $display("[TB] test_mid_frame done");
    endtask

    task automatic test_force_in_debug();
        do_reset(GAME_A);
        while (t < 20) tick();
        debug_valid  = 1'b1;
        debug_digits = DBG_A;
        tick();
        debug_valid = 1'b0;
        while (t < 25) begin
            tests_run++;
            if (debug_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL force_ready_dbg t=%0d got %b want 0", t, debug_ready);
            end
            tick();
        end
        force_game = 1'b1;
        #1;
        tests_run++;
        if (debug_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL force_ready_held got %b want 0", debug_ready);
        end
        tick();
        force_game = 1'b0;
        #1;
        while (t <= 70) begin
            tests_run++;
            if (debug_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL force_ready_after t=%0d got %b want 1", t, debug_ready);
            end
            tests_run++;
            if (owner !== 1'b0) begin
                tests_failed++;
                $display("FAIL force_owner t=%0d got %b want 0", t, owner);
            end
            tests_run++;
            if ({digit, abcdefgh} !== exp_scan(t - 1, GAME_A)) begin
                tests_failed++;
                $display("FAIL force_scan t=%0d got digit=%b seg=%h want %h", t, digit, abcdefgh, exp_scan(t - 1, GAME_A));
            end
            tick();
        end
        $display("[TB] test_force_in_debug done");
    endtask

    task automatic test_force_and_request();
        do_reset(GAME_A);
        while (t < 5) tick();
        force_game   = 1'b1;
        debug_valid  = 1'b1;
        debug_digits = DBG_A;
        #1;
        while (t <= 40) begin
            tests_run++;
            if (debug_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL both_ready t=%0d got %b want 0", t, debug_ready);
            end
            tests_run++;
            if (owner !== 1'b0) begin
                tests_failed++;
                $display("FAIL both_owner t=%0d got %b want 0", t, owner);
            end
            tests_run++;
            if ({digit, abcdefgh} !== exp_scan(t - 1, GAME_A)) begin
                tests_failed++;
                $display("FAIL both_scan t=%0d got digit=%b seg=%h want %h", t, digit, abcdefgh, exp_scan(t - 1, GAME_A));
            end
            tick();
        end
        force_game  = 1'b0;
        debug_valid = 1'b0;
        #1;
        tests_run++;
        if (debug_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL both_ready_release got %b want 1", debug_ready);
        end
        $display("[TB] test_force_and_request done");
    endtask

    task automatic test_reset_mid_slot();
        do_reset(GAME_A);
        while (t < 30) tick();
        debug_valid  = 1'b1;
        debug_digits = DBG_A;
        tick();
        debug_valid = 1'b0;
        while (t < 52) tick();
        tests_run++;
        if ({owner, digit, abcdefgh} !== {1'b1, 4'b0100, 8'hCC}) begin
            tests_failed++;
            $display("FAIL rstmid_before got owner=%b digit=%b seg=%h want 1/0100/cc", owner, digit, abcdefgh);
        end
        rst         = 1'b1;
        game_digits = GAME_B;
        tick();
        tests_run++;
        if ({owner, digit, abcdefgh} !== 13'h0) begin
            tests_failed++;
            $display("FAIL rstmid_out got owner=%b digit=%b seg=%h want 0", owner, digit, abcdefgh);
        end
        tests_run++;
        if (debug_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_ready got %b want 0", debug_ready);
        end
        rst = 1'b0;
        t   = 0;
        #1;
        tests_run++;
        if ({owner, digit, abcdefgh, debug_ready} !== 14'h0) begin
            tests_failed++;
            $display("FAIL rstmid_first got owner=%b digit=%b seg=%h ready=%b want 0", owner, digit, abcdefgh, debug_ready);
        end
        tick();
        while (t <= 40) begin
            tests_run++;
            if (owner !== 1'b0) begin
                tests_failed++;
                $display("FAIL rstmid_owner t=%0d got %b want 0", t, owner);
            end
            tests_run++;
            if (debug_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL rstmid_ready_after t=%0d got %b want 1", t, debug_ready);
            end
            tests_run++;
            if ({digit, abcdefgh} !== exp_scan(t - 1, GAME_B)) begin
                tests_failed++;
                $display("FAIL rstmid_scan t=%0d got digit=%b seg=%h want %h", t, digit, abcdefgh, exp_scan(t - 1, GAME_B));
            end
            tick();
        end
        $display("[TB] test_reset_mid_slot done");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_debug_handshake();
        test_mid_frame();
        test_force_in_debug();
        test_force_and_request();
        test_reset_mid_slot();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg7_display_scheduler.md
Name: seg7_display_scheduler

Overview:
- Drives the shared multiplexed seven-segment display for the game platform.
- Scans digits at a controlled refresh rate, with inter-digit blanking to suppress ghosting.
- Latches a tear-free per-frame snapshot of the source data.
- Arbitrates display ownership between the game status source (score/lives) and a timed debug-message requester; sits between game logic and the board `abcdefgh`/`digit` pins.

Parameters:
- w_digit, 4, number of digits scanned; one 8-bit segment field per digit.
- slot_cycles, 12500, clk cycles per digit slot (50 MHz / 4 kHz).
- blank_cycles, 16, leading cycles of each slot with all digits off; must be < slot_cycles.
- ms_cycles, 50000, clk cycles per hold-timer tick (1 ms at 50 MHz).
- hold_ms, 2000, debug-message display time in ticks.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- game_digits  in  w_digit*8  game segment patterns; field i = bits [i*8 +: 8], bit order abcdefgh
- debug_valid  in  1  debug message request
- debug_digits  in  w_digit*8  debug segment patterns, same layout
- debug_ready  out  1  debug message may be accepted this cycle
- force_game  in  1  cancel debug ownership
- abcdefgh  out  8  active-high segment outputs
- digit  out  w_digit  one-hot active-high digit enable
- owner  out  1  source of the current frame: 0 = game, 1 = debug

Behaviour:
- Reset: rst synchronous, active-high; clock clk. While rst is high, and on the first cycle after:
  - abcdefgh=0, digit=0, owner=0, debug_ready=0.
  - Slot index = 0, slot counter = 0, hold counter = 0, ms prescaler = 0.
  - Both frame buffers cleared; requested owner = GAME.
- Scan timing:
  - Slot counter counts 0 to slot_cycles-1 and wraps.
  - At wrap, slot index increments 0 to w_digit-1 and wraps to 0.
  - One frame = w_digit*slot_cycles cycles.
- Scan FSM per slot, states BLANK and ACTIVE:
  - BLANK while slot counter < blank_cycles: digit=0, abcdefgh=0.
  - ACTIVE otherwise: digit = 1<<index, abcdefgh = snapshot field[index].
  - abcdefgh and digit are registered, with 1-cycle latency from the counter state.
- Frame boundary = slot counter 0 with index 0. On that cycle:
  - The snapshot loads from game_digits if requested owner = GAME, else from the debug buffer.
  - owner updates to the requested owner.
  - Source changes mid-frame are never visible before the next boundary.
- Ownership FSM, states GAME and DEBUG:
  - debug_ready = (state==GAME) && !force_game && !rst. This is combinational on force_game.
  - In GAME, debug_valid && debug_ready: latch debug_digits into the debug buffer, go to DEBUG, load hold counter = hold_ms, clear ms prescaler.
  - In DEBUG: ms prescaler counts to ms_cycles-1 and wraps, decrementing the hold counter at each wrap. When the hold counter reaches 0, go to GAME.
  - In DEBUG, debug_valid is ignored (ready=0); the requester waits.
  - force_game=1 in any state: go to GAME next cycle, hold counter = 0. Force takes priority over acceptance and over expiry in the same cycle.
  - Visible owner changes only at the next frame boundary, so a DEBUG request shorter than one frame may never appear. This is intended.
- Width rules:
  - Counters are sized $clog2 of their maximum value, minimum 1 bit.
  - hold_ms=0 means DEBUG exits on the cycle after acceptance.
- Reset mid-slot or mid-hold: outputs go to 0 at the next edge; the scan restarts at index 0 in BLANK; a pending debug message is dropped.

Decomposition:
- Package seg7_pkg:
  - seven_seg_encoding_e (ZERO, ONE, TWO, THREE, FOUR, SPACE, S, L).
  - owner_e (OWNER_GAME, OWNER_DEBUG).
  - scan_state_e (BLANK, ACTIVE).
- Sub-module seg7_strobe_gen (parameter period_cycles; ports clk, rst, clr, strobe). Instantiated once for the slot wrap and once for the ms tick.

Test Plan:
1. Scan timing. Params slot_cycles=8, blank_cycles=2, ms_cycles=10, hold_ms=3; game_digits=32'h44_33_22_11.
   - Every slot k: 2 cycles digit=0/abcdefgh=0, then 6 cycles digit=1<<k and abcdefgh=8'h11,22,33,44 for k=0..3.
   - Frame period = 32 cycles.
2. Debug handshake. debug_valid with debug_digits=32'hDD_CC_BB_AA.
   - Accepted in a cycle with ready=1; ready=0 from the next cycle.
   - owner=1 from the next frame boundary; fields show AA..DD.
   - DEBUG state lasts 30 cycles; owner=0 at the first frame boundary after that; ready=1.
3. Mid-frame change. Change game_digits to 32'h0 at cycle 10 of a frame: segments unchanged until cycle 32, then abcdefgh=0 in all ACTIVE slots.
4. Force during DEBUG. force_game pulse 5 cycles into DEBUG: ready=1 on the following cycle once force drops; owner=0 at the next boundary.
5. Simultaneous force and request. force_game=1 and debug_valid=1 in GAME: ready=0, no acceptance, owner stays 0.
6. Reset mid-slot. rst in ACTIVE slot 2: digit=0, abcdefgh=0, owner=0 next cycle; after release, slot 0 BLANK begins and the snapshot reloads.
